// File: rtl/park_transform.sv
// ---------------------------------------------------------------------------
// park_transform
//
// Park transform (alpha/beta -> d/q) built around one shared 16x16 signed
// multiplier. A rising edge on iPark_en latches the four operands. The four
// products are then formed on four consecutive cycles into two 33-bit
// accumulators. The outputs are rounded, saturated and registered in a final
// DONE cycle.
//
//   Id = Ialpha*cos + Ibeta*sin
//   Iq = Ibeta*cos  - Ialpha*sin
//
// Ports
//   iClk        rising-edge clock
//   iRst_n      asynchronous active-low reset
//   iPark_en    start request; a 0->1 transition starts one transform
//   iIalpha     signed alpha-axis current
//   iIbeta      signed beta-axis current
//   iSin        signed sin(theta), Q1.15
//   iCos        signed cos(theta), Q1.15
//   oId         signed d-axis current; holds its value between results
//   oIq         signed q-axis current; holds its value between results
//   oBusy       high from the trigger edge until the result is written
//   oPark_done  one-cycle pulse coincident with a new oId/oIq
//
// Timing: trigger at edge k -> oBusy high after edges k..k+4,
//         oId/oIq/oPark_done valid after edge k+5.
// ---------------------------------------------------------------------------
module park_transform (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iPark_en,
  input  logic signed [15:0] iIalpha,
  input  logic signed [15:0] iIbeta,
  input  logic signed [15:0] iSin,
  input  logic signed [15:0] iCos,
  output logic signed [15:0] oId,
  output logic signed [15:0] oIq,
  output logic               oBusy,
  output logic               oPark_done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL0 = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    MUL3 = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state, state_next;

  // Previous sample of iPark_en, used for rising-edge detection.
  logic en_prev;
  logic trigger;

  // Operands captured at the trigger edge.
  logic signed [15:0] ia, ib, sin_q, cos_q;

  // Accumulators are one bit wider than a product, so the sum of two
  // full-scale products cannot overflow.
  logic signed [32:0] acc_d, acc_q;
  logic signed [32:0] acc_d_next, acc_q_next;

  logic signed [15:0] id_next, iq_next;
  logic               busy_next, done_next, load;

  // Shared multiplier and its operand muxes.
  logic signed [15:0] mul_a, mul_b;
  logic signed [31:0] mul_a_ext, mul_b_ext;
  logic signed [31:0] product;
  logic signed [32:0] prod_ext;

  assign trigger = iPark_en & ~en_prev;

  // Ialpha is used in MUL0 and MUL2, Ibeta in MUL1 and MUL3.
  // cos is used in MUL0 and MUL3, sin in MUL1 and MUL2.
  assign mul_a = (state == MUL0 || state == MUL2) ? ia : ib;
  assign mul_b = (state == MUL0 || state == MUL3) ? cos_q : sin_q;

  assign mul_a_ext = {{16{mul_a[15]}}, mul_a};
  assign mul_b_ext = {{16{mul_b[15]}}, mul_b};
  assign product   = mul_a_ext * mul_b_ext;
  assign prod_ext  = {product[31], product};

  // Round half up, then clamp to the 16-bit signed range.
  function automatic logic signed [15:0] scale_sat(input logic signed [32:0] acc);
    logic signed [33:0] wide;
    logic signed [33:0] shifted;
    wide    = acc;
    shifted = (wide + 34'sd16384) >>> 15;
    if (shifted > 34'sd32767)
      scale_sat = 16'sh7fff;
    else if (shifted < -34'sd32768)
      scale_sat = 16'sh8000;
    else
      scale_sat = shifted[15:0];
  endfunction

  // Next-state and datapath control.
  always_comb begin
    state_next = state;
    acc_d_next = acc_d;
    acc_q_next = acc_q;
    id_next    = oId;
    iq_next    = oIq;
    busy_next  = oBusy;
    done_next  = 1'b0;
    load       = 1'b0;

    case (state)
      IDLE: begin
        if (trigger) begin
          state_next = MUL0;
          busy_next  = 1'b1;
          load       = 1'b1;
        end
      end
      MUL0: begin
        acc_d_next = prod_ext;
        state_next = MUL1;
      end
      MUL1: begin
        acc_d_next = acc_d + prod_ext;
        state_next = MUL2;
      end
      MUL2: begin
        acc_q_next = -prod_ext;
        state_next = MUL3;
      end
      MUL3: begin
        acc_q_next = acc_q + prod_ext;
        state_next = DONE;
      end
      DONE: begin
        id_next    = scale_sat(acc_d);
        iq_next    = scale_sat(acc_q);
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= IDLE;
      en_prev    <= 1'b0;
      ia         <= '0;
      ib         <= '0;
      sin_q      <= '0;
      cos_q      <= '0;
      acc_d      <= '0;
      acc_q      <= '0;
      oId        <= '0;
      oIq        <= '0;
      oBusy      <= 1'b0;
      oPark_done <= 1'b0;
    end else begin
      state      <= state_next;
      en_prev    <= iPark_en;
      acc_d      <= acc_d_next;
      acc_q      <= acc_q_next;
      oId        <= id_next;
      oIq        <= iq_next;
      oBusy      <= busy_next;
      oPark_done <= done_next;
      if (load) begin
        ia    <= iIalpha;
        ib    <= iIbeta;
        sin_q <= iSin;
        cos_q <= iCos;
      end
    end
  end

endmodule

// File: doc/park_transform.md
PARK_TRANSFORM -- requirements
Module: park_transform

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with these ports:
- iClk  input  1  rising-edge clock
- iRst_n  input  1  asynchronous, active-low reset
REQ-002 iPark_en  input  1  start request; a 0->1 transition triggers one transform.
REQ-003 iIalpha  input  16  signed alpha-axis current.
REQ-004 iIbeta  input  16  signed beta-axis current.
REQ-005 iSin  input  16  signed sin(theta), Q1.15 (32767 ~ +1.0), from the sin/cos CORDIC stage.
REQ-006 iCos  input  16  signed cos(theta), Q1.15, from the sin/cos CORDIC stage.
REQ-007 oId  output  16  signed d-axis current.
REQ-008 oIq  output  16  signed q-axis current.
REQ-009 oBusy  output  1  high from trigger until the result is written.
REQ-010 oPark_done  output  1  one-cycle pulse marking a new result.

Function
REQ-011 SHALL compute Id = Ialpha*cos + Ibeta*sin and Iq = Ibeta*cos - Ialpha*sin.
REQ-012 SHALL detect the trigger as iPark_en high at a clock edge while the registered previous sample of iPark_en is low; the previous-sample register resets to 0.
REQ-013 SHALL latch iIalpha, iIbeta, iSin and iCos at the trigger edge; later input changes SHALL NOT affect that result.
REQ-014 SHALL use exactly one shared 16x16 signed multiplier, time-multiplexed across the four products.
REQ-015 FSM states and transitions:
- IDLE -> MUL0 on trigger.
- MUL0: accD = Ia*cos.
- MUL1: accD += Ib*sin.
- MUL2: accQ = -(Ia*sin).
- MUL3: accQ += Ib*cos.
- DONE -> IDLE.
REQ-016 SHALL hold both accumulators at 33 bits signed, so no intermediate overflow occurs.
REQ-017 Scaling: each result = (acc + 16384) >>> 15 (arithmetic shift, round half up), then saturated to [-32768, 32767].
REQ-018 In DONE, SHALL update oId and oIq and assert oPark_done for exactly one cycle on the same edge.
REQ-019 Latency: trigger at edge k -> oId, oIq and oPark_done valid after edge k+5.
REQ-020 oBusy SHALL be high after edges k through k+4 and low after edge k+5.
REQ-021 SHALL ignore rising edges of iPark_en while oBusy is high; they are not queued.
REQ-022 iPark_en held high SHALL produce only one transform.
REQ-023 A new rising edge in the cycle after oPark_done SHALL be accepted.
REQ-024 oId and oIq SHALL hold their last values between completions.

Reset
REQ-025 While iRst_n is low, SHALL force: state = IDLE, oId = 0, oIq = 0, oBusy = 0, oPark_done = 0, accumulators = 0, latched operands = 0.
REQ-026 A reset asserted mid-transform SHALL abort it with no done pulse.
REQ-027 If iPark_en is already high when reset releases, the first clock edge SHALL count as a trigger.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Ia=16384, Ib=0, sin=0, cos=32767 -> Id=16384, Iq=0; done pulse after edge k+5.
- Ia=0, Ib=16384, sin=32767, cos=0 -> Id=16384, Iq=0.
- Ia=-16384, Ib=0, sin=0, cos=32767 -> Id=-16383, Iq=0 (rounding asymmetry).
- Ia=Ib=32767, sin=cos=32767 -> Id saturates to 32767, Iq=0; Ia=Ib=sin=cos=-32768 -> Id=32767, Iq=0.
- Second iPark_en edge at k+2 -> ignored, single done pulse; inputs changed at k+1 -> result uses values latched at k.
- iRst_n low at k+3 -> all outputs 0, no done pulse; after release, a fresh trigger completes normally in 5 cycles.
